// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mc_pkg
//  Brief   : Shared types and encodings for the multicycle RV32I controller:
//            FSM state enum, opcodes, mux-select and ALU encodings.
//  Rev     : 1.0  initial release
// ============================================================================
package mc_pkg;

  // Controller states
  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    JAL,
    ALUWB,
    BEQ,
    HALT
  } statetype_t;

  // Opcodes (Instr[6:0])
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // ALUSrcA selects
  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_OLDPC = 2'b01;
  localparam logic [1:0] SA_REGA  = 2'b10;

  // ALUSrcB selects
  localparam logic [1:0] SB_REGB  = 2'b00;
  localparam logic [1:0] SB_IMM   = 2'b01;
  localparam logic [1:0] SB_FOUR  = 2'b10;

  // ResultSrc selects
  localparam logic [1:0] RS_ALUOUT    = 2'b00;
  localparam logic [1:0] RS_DATA      = 2'b01;
  localparam logic [1:0] RS_ALURESULT = 2'b10;

  // ALUOp encodings (controller -> ALU decoder)
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ImmSrc encodings
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ALUControl encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage : mc_pkg
`default_nettype wire

// File: rtl/mc_aludec.sv
`default_nettype none
// ============================================================================
//  Module  : mc_aludec
//  Brief   : ALU decoder. Maps ALUOp plus funct3/funct7b5/op[5] onto the
//            3-bit ALUControl code; every unlisted combination resolves to
//            add so the output is never X.
//  Rev     : 1.0  initial release
// ============================================================================
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alucontrol
);

  // sub only for R-type (op[5]=1) with funct7b5 set; addi is always add
  logic w_rtype_sub;
  assign w_rtype_sub = i_funct7b5 & i_op5;

  // Decode ALU operation, defaulting to add
  always_comb begin
    o_alucontrol = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALU_ADD;
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alucontrol = w_rtype_sub ? ALU_SUB : ALU_ADD;
          3'b010:  o_alucontrol = ALU_SLT;
          3'b110:  o_alucontrol = ALU_OR;
          3'b111:  o_alucontrol = ALU_AND;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      default: o_alucontrol = ALU_ADD;
    endcase
  end

endmodule : mc_aludec
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module  : multicycle_controller
//  Brief   : Sequencing FSM for the multicycle RV32I core. Drives per-cycle
//            enables and mux selects for PC, IR, register file, unified
//            memory and ALU, handshakes with memory via MemReq/MemReady and
//            counts retired instructions.
//  Rev     : 1.0  initial release
// ============================================================================
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             Halted,
  output logic [CNT_W-1:0] InstrRetired
);

  statetype_t       r_state;
  statetype_t       w_state_next;
  logic [CNT_W-1:0] r_instr_retired;

  logic       w_memreq;
  logic       w_adrsrc;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_pcupdate;
  logic       w_branch;
  logic       w_regwrite;
  logic [1:0] w_resultsrc;
  logic [1:0] w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_aluop;
  logic       w_halted;
  logic       w_retire;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FETCH;
    else        r_state <= w_state_next;
  end

  // Next-state and Moore output decode; FETCH handshake bits follow MemReady
  always_comb begin
    w_state_next = r_state;
    w_memreq     = 1'b0;
    w_adrsrc     = 1'b0;
    w_memwrite   = 1'b0;
    w_irwrite    = 1'b0;
    w_pcupdate   = 1'b0;
    w_branch     = 1'b0;
    w_regwrite   = 1'b0;
    w_resultsrc  = RS_ALURESULT;
    w_alusrca    = SA_PC;
    w_alusrcb    = SB_FOUR;
    w_aluop      = ALUOP_ADD;
    w_halted     = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      FETCH: begin
        w_memreq   = 1'b1;
        w_irwrite  = MemReady;
        w_pcupdate = MemReady;
        if (MemReady) w_state_next = DECODE;
      end
      DECODE: begin
        // Precompute branch/jump target into ALUOut
        w_alusrca = SA_OLDPC;
        w_alusrcb = SB_IMM;
        case (op)
          OP_LW, OP_SW: w_state_next = MEMADR;
          OP_R:         w_state_next = EXECR;
          OP_I:         w_state_next = EXECI;
          OP_JAL:       w_state_next = JAL;
          OP_BEQ:       w_state_next = BEQ;
          default:      w_state_next = HALT;
        endcase
      end
      MEMADR: begin
        w_alusrca    = SA_REGA;
        w_alusrcb    = SB_IMM;
        w_state_next = op[5] ? MEMWR : MEMREAD;
      end
      MEMREAD: begin
        w_memreq    = 1'b1;
        w_adrsrc    = 1'b1;
        w_resultsrc = RS_ALUOUT;
        if (MemReady) w_state_next = MEMWB;
      end
      MEMWB: begin
        w_resultsrc  = RS_DATA;
        w_regwrite   = 1'b1;
        w_retire     = 1'b1;
        w_state_next = FETCH;
      end
      MEMWR: begin
        // MemWrite stays asserted for the whole wait, not gated by MemReady
        w_memreq    = 1'b1;
        w_memwrite  = 1'b1;
        w_adrsrc    = 1'b1;
        w_resultsrc = RS_ALUOUT;
        if (MemReady) begin
          w_retire     = 1'b1;
          w_state_next = FETCH;
        end
      end
      EXECR: begin
        w_alusrca    = SA_REGA;
        w_alusrcb    = SB_REGB;
        w_aluop      = ALUOP_FUNCT;
        w_state_next = ALUWB;
      end
      EXECI: begin
        w_alusrca    = SA_REGA;
        w_alusrcb    = SB_IMM;
        w_aluop      = ALUOP_FUNCT;
        w_state_next = ALUWB;
      end
      JAL: begin
        // Link value OldPC+4 computed while PC takes the target from ALUOut
        w_alusrca    = SA_OLDPC;
        w_alusrcb    = SB_FOUR;
        w_resultsrc  = RS_ALUOUT;
        w_pcupdate   = 1'b1;
        w_state_next = ALUWB;
      end
      ALUWB: begin
        w_resultsrc  = RS_ALUOUT;
        w_regwrite   = 1'b1;
        w_retire     = 1'b1;
        w_state_next = FETCH;
      end
      BEQ: begin
        w_alusrca    = SA_REGA;
        w_alusrcb    = SB_REGB;
        w_aluop      = ALUOP_SUB;
        w_resultsrc  = RS_ALUOUT;
        w_branch     = 1'b1;
        w_retire     = 1'b1;
        w_state_next = FETCH;
      end
      HALT: begin
        w_halted     = 1'b1;
        w_state_next = HALT;
      end
      default: w_state_next = FETCH;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_instr_retired <= '0;
    else if (w_retire) r_instr_retired <= r_instr_retired + CNT_W'(1);
  end

  // Immediate format straight from the opcode
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_LW, OP_I: ImmSrc = IMM_I;
      OP_SW:       ImmSrc = IMM_S;
      OP_BEQ:      ImmSrc = IMM_B;
      OP_JAL:      ImmSrc = IMM_J;
      default:     ImmSrc = IMM_I;
    endcase
  end

  mc_aludec u_aludec (
    .i_aluop      (w_aluop),
    .i_funct3     (funct3),
    .i_funct7b5   (funct7b5),
    .i_op5        (op[5]),
    .o_alucontrol (ALUControl)
  );

  // Enables are forced low combinationally while reset is held, so a
  // pending memory write is withdrawn without waiting for a clock edge
  assign MemReq       = reset & w_memreq;
  assign MemWrite     = reset & w_memwrite;
  assign IRWrite      = reset & w_irwrite;
  assign PCWrite      = reset & (w_pcupdate | (w_branch & Zero));
  assign RegWrite     = reset & w_regwrite;
  assign AdrSrc       = w_adrsrc;
  assign ResultSrc    = w_resultsrc;
  assign ALUSrcA      = w_alusrca;
  assign ALUSrcB      = w_alusrcb;
  assign Halted       = reset & w_halted;
  assign InstrRetired = r_instr_retired;

endmodule : multicycle_controller
`default_nettype wire
